// File: rtl/full_adder_reg_pkg.sv
// Shared constants for the registered full adder and its testbench.
package full_adder_reg_pkg;

    localparam int FA_MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder_reg_if.sv
// Operand/result bundle for full_adder_reg.
// Handshake: in_valid qualifies a, b and ci on a rising edge. There is no
// ready, so every valid beat is accepted. out_valid marks the cycle after an
// accepted beat; sum and carry hold their last result while out_valid is low.
interface full_adder_reg_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             out_valid;

    modport master (
        output in_valid, a, b, ci,
        input  sum, carry, out_valid
    );

    modport slave (
        input  in_valid, a, b, ci,
        output sum, carry, out_valid
    );
endinterface

// File: rtl/fa_cell.sv
// One-bit combinational full adder; the ripple element of full_adder_reg.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

// File: rtl/full_adder_reg.sv
// Registered WIDTH-bit ripple-carry adder: {carry, sum} = a + b + ci, one cycle
// of latency, loaded only on in_valid.
module full_adder_reg
    import full_adder_reg_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    full_adder_reg_if.slave   bus
);
    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $error("full_adder_reg: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = bus.ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_cell u_cell (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;

    // Idle cycles keep the previous result, so stray operands cannot leak in.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            sum_d   = s;
            carry_d = c[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_full_adder_reg.sv
// Bench for full_adder_reg at WIDTH 1, 8 and 16 against an arithmetic model.
module tb_full_adder_reg;
    import full_adder_reg_pkg::*;

    logic clk;
    logic rst;

    full_adder_reg_if #(.WIDTH(1))  bus1 ();
    full_adder_reg_if #(.WIDTH(8))  bus8 ();
    full_adder_reg_if #(.WIDTH(16)) bus16 ();

    full_adder_reg #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    full_adder_reg #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    full_adder_reg #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus state (index 0:W1, 1:W8, 2:W16) ----------------
    logic        in_v [3];
    logic [63:0] op_a [3];
    logic [63:0] op_b [3];
    logic        op_c [3];
    int          widths [3] = '{1, 8, 16};

    assign bus1.in_valid  = in_v[0];
    assign bus1.a         = op_a[0][0:0];
    assign bus1.b         = op_b[0][0:0];
    assign bus1.ci        = op_c[0];
    assign bus8.in_valid  = in_v[1];
    assign bus8.a         = op_a[1][7:0];
    assign bus8.b         = op_b[1][7:0];
    assign bus8.ci        = op_c[1];
    assign bus16.in_valid = in_v[2];
    assign bus16.a        = op_a[2][15:0];
    assign bus16.b        = op_b[2][15:0];
    assign bus16.ci       = op_c[2];

    // ---------------- reference model ----------------
    logic [63:0] m_sum   [3];
    logic        m_carry [3];
    logic        m_valid [3];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input int k, input logic v, input logic [63:0] a,
                          input logic [63:0] b, input logic c);
        in_v[k] = v;
        op_a[k] = a;
        op_b[k] = b;
        op_c[k] = c;
    endtask

    task automatic set_rand(input int k, input bit allow_idle);
        logic v;
        v = allow_idle ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!v && $urandom_range(0, 1) == 1)
            set_in(k, 1'b0, 'x, 'x, 1'bx);
        else
            set_in(k, v, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare.
    task automatic tick(input string phase);
        logic [63:0] mask;
        logic [64:0] total;
        logic [63:0] g_sum;
        logic        g_carry, g_valid;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            mask = (widths[k] >= 64) ? '1 : ((64'd1 << widths[k]) - 64'd1);
            if (rst) begin
                m_sum[k]   = '0;
                m_carry[k] = 1'b0;
                m_valid[k] = 1'b0;
            end else if (in_v[k]) begin
                total      = {1'b0, op_a[k] & mask} + {1'b0, op_b[k] & mask} + 65'(op_c[k]);
                m_sum[k]   = total[63:0] & mask;
                m_carry[k] = total[widths[k]];
                m_valid[k] = 1'b1;
            end else begin
                m_valid[k] = 1'b0;
            end
            case (k)
                0: begin g_sum = 64'(bus1.sum);  g_carry = bus1.carry;  g_valid = bus1.out_valid;  end
                1: begin g_sum = 64'(bus8.sum);  g_carry = bus8.carry;  g_valid = bus8.out_valid;  end
                default: begin g_sum = 64'(bus16.sum); g_carry = bus16.carry; g_valid = bus16.out_valid; end
            endcase
            check_val($sformatf("%s w%0d sum", phase, widths[k]), g_sum, m_sum[k]);
            check_val($sformatf("%s w%0d carry", phase, widths[k]), 64'(g_carry), 64'(m_carry[k]));
            check_val($sformatf("%s w%0d out_valid", phase, widths[k]), 64'(g_valid), 64'(m_valid[k]));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [2:0]  tt;
        logic [63:0] vec_a [4] = '{64'hFF, 64'hFF, 64'h00, 64'h7F};
        logic [63:0] vec_b [4] = '{64'h01, 64'hFF, 64'h00, 64'h00};
        logic        vec_c [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) set_in(k, 1'b1, '1, '1, 1'b1);
        tick("reset0");
        tick("reset1");
        rst = 1'b0;
        tick("first_after_reset");

        for (int i = 0; i < 8; i++) begin
            tt = 3'(i);
            set_in(0, 1'b1, 64'(tt[1]), 64'(tt[0]), tt[2]);
            set_rand(1, 1'b0);
            set_rand(2, 1'b0);
            tick($sformatf("truth%0d", i));
        end

        for (int k = 0; k < 3; k++) set_in(k, 1'b1, 64'd1, 64'd1, 1'b0);
        tick("hold_load");
        for (int k = 0; k < 3; k++) set_in(k, 1'b0, 64'd0, 64'd0, 1'b1);
        tick("hold_idle");
        for (int k = 0; k < 3; k++) set_in(k, 1'b0, 'x, 'x, 1'bx);
        tick("hold_x");

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) set_in(k, 1'b1, vec_a[i], vec_b[i], vec_c[i]);
            tick($sformatf("w8_edge%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            rst = (i == 6);
            for (int k = 0; k < 3; k++) begin
                set_rand(k, 1'b0);
                in_v[k] = (i % 2 == 0);
            end
            tick($sformatf("midrst%0d", i));
        end
        rst = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < 3; k++) set_rand(k, 1'b1);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
Registered full adder. Computes {carry, sum} = a + b + ci for WIDTH-bit operands with a ripple chain of 1-bit full-adder cells. Results are captured in output registers on the rising clock edge. With WIDTH=1 it is the classic 1-bit full adder with one cycle of latency. It serves as the arithmetic leaf for datapath blocks that need a registered add with carry-in and carry-out.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle; enables the output register load.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- ci  input  1  carry-in.
- sum  output  WIDTH  registered sum, (a+b+ci) mod 2^WIDTH.
- carry  output  1  registered carry-out, bit WIDTH of a+b+ci.
- out_valid  output  1  sum/carry hold a result from a valid input.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst sampled on the clk rising edge).
- Reset values: sum=0, carry=0, out_valid=0.
- Reset has priority over everything. If rst=1 at an edge, all outputs go to their reset values regardless of in_valid.
- Cell function, for each bit i:
  - s_i = a_i ^ b_i ^ c_i
  - c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i))
  - c_0 = ci; carry = c_WIDTH.
- The adder chain is purely combinational. The only state is sum, carry and out_valid.
- Latency is exactly 1 cycle. If in_valid=1 at edge N, sum and carry show the result of edge-N inputs after edge N, and out_valid=1.
- If in_valid=0 at an edge (rst=0): sum and carry hold their previous values; out_valid goes to 0 on that edge.
- Back-to-back valid inputs give one result per cycle. There is no backpressure and no ready signal.
- Overflow wraps: sum is modulo 2^WIDTH and the overflow appears only on carry. There is no saturation.
- Operands are unsigned. Signed interpretation (if any) is left to the consumer.
- X on the inputs while in_valid=0 must not disturb the held outputs.
- No internal state other than the output registers. After reset deassertion the block accepts in_valid in the first cycle.

Decomposition:
- Shared package: no typedefs required. A package constant FA_MAX_WIDTH=64 may be shared for parameter checks.
- Sub-module: fa_cell (1-bit combinational full adder; ports a, b, ci, s, co), instantiated WIDTH times in a generate loop.
- full_adder_reg itself holds the chain, the output registers and an elaboration-time check that WIDTH is within 1..FA_MAX_WIDTH.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and a=b=ci=1. Required: sum=0, carry=0, out_valid=0 throughout; first valid result appears one cycle after rst drops.
- Exhaustive truth table, WIDTH=1, one combination per cycle, each with in_valid=1. Required {ci,a,b} -> {sum,carry} one cycle later:
  - 000->0,0; 100->1,0; 010->1,0; 110->0,1
  - 001->1,0; 101->0,1; 011->0,1; 111->1,1
- Hold: WIDTH=1, apply a=1, b=1, ci=0 valid, then in_valid=0 with a=0, b=0, ci=1. Required: sum=0, carry=1 remain; out_valid goes 1 then 0.
- Wrap, WIDTH=8: a=0xFF, b=0x01, ci=0 -> sum=0x00, carry=1. Also a=0xFF, b=0xFF, ci=1 -> sum=0xFF, carry=1.
- Carry-in only, WIDTH=8: a=0x00, b=0x00, ci=1 -> sum=0x01, carry=0. Full-chain ripple: a=0x7F, b=0x00, ci=1 -> sum=0x80, carry=0.
- Reset mid-stream: alternate valid inputs each cycle and assert rst for one cycle. Required: that edge clears all outputs; the stream resumes one cycle later with correct results; random WIDTH=16 vectors match a+b+ci for 1000 cycles.
